trng_cell_ctrl: RTL and testbench
=================================

Name: trng_cell_ctrl

Overview:
- Sequencer for one RS-latch entropy cell in the TRNG datapath.
- Each trial drives R=S=1 (forbidden state), then releases both together so the latch resolves metastably. It then samples Q through a 2-FF synchroniser.
- Applies optional von Neumann debiasing and a repetition-count health test, and packs accepted bits into WIDTH-bit words.
- Words are delivered over a valid/ready handshake to the downstream collector.

Parameters:
- WIDTH, 8: output word width in accepted bits.
- EXCITE_CYC, 2: cycles R=S=1 per trial (>=1).
- SETTLE_CYC, 4: cycles R=S=0 before sampling. Must be >=2 to cover synchroniser latency; elaboration error otherwise.
- RCT_LIMIT, 16: run length of identical raw bits that flags a health failure (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- vn_en  in  1  von Neumann debiasing enable; sampled only in IDLE.
- cell_q  in  1  asynchronous Q output of the RS cell.
- cell_r  out  1  R drive to the cell.
- cell_s  out  1  S drive to the cell.
- data_out  out  WIDTH  packed random word.
- data_valid  out  1  data_out is valid.
- data_ready  in  1  consumer accepts the word.
- health_fail  out  1  sticky repetition-count failure flag.

Behaviour:
- Reset: synchronous on rising clk with rst=1.
  - Outputs: cell_r=0, cell_s=0, data_out=0, data_valid=0, health_fail=0.
  - Internal: state=IDLE, all counters, synchroniser and shift register cleared.
  - rst mid-operation aborts everything and discards any partial word.
- cell_q passes through a 2-FF synchroniser (q_sync). Raw bit = q_sync value during SAMPLE.
- States and transitions:
  - IDLE: R=S=0. If en=1, latch vn_en and go to EXCITE.
  - EXCITE: R=S=1 for EXCITE_CYC cycles, then SETTLE.
  - SETTLE: R=S=0 for SETTLE_CYC cycles, then SAMPLE.
  - SAMPLE: one cycle. Raw bit captured at the closing edge, then processed:
    - RCT first.
    - Then debias (or pass through when vn_en=0).
    - Then shift.
  - After SAMPLE: HOLD if word complete; FAIL if RCT fired; otherwise EXCITE.
  - HOLD: R=S=0, data_valid=1, data_out stable. On data_valid & data_ready, go to EXCITE next cycle if en=1, else IDLE; data_valid=0 that cycle.
  - FAIL: R=S=0, data_valid=0, health_fail=1. Only rst exits.
- Trial period: EXCITE_CYC+SETTLE_CYC+1 cycles.
- Packing: shift left, LSB insert, so the first accepted bit ends in MSB.
  - A bit counter of clog2(WIDTH+1) bits counts accepted bits.
  - Word complete at WIDTH; counter clears on entry to HOLD.
- Von Neumann:
  - Raw bits pair in capture order: first, second.
  - 01 emits 0; 10 emits 1; 00 and 11 emit nothing.
  - The pair slot resets on IDLE entry.
- RCT:
  - Run counter is saturating, width clog2(RCT_LIMIT+1).
  - Equal to previous raw bit: increment. Otherwise: reset to 1. First bit after reset/IDLE: 1.
  - Counter reaching RCT_LIMIT: FAIL.
  - RCT operates on raw bits regardless of vn_en.
  - The failing bit is not shifted in, and the partial word is discarded.
- en=0 in EXCITE, SETTLE or SAMPLE: go to IDLE next edge; partial word and pair slot discarded.
- en=0 in HOLD: word held until the handshake completes.
- data_ready is ignored outside HOLD. No trials run while HOLD waits (back-pressure).
- R and S always switch on the same edge, both from registered outputs. No glitch path from state decode.

Decomposition:
- Package trng_pkg holds:
  - state enum (IDLE, EXCITE, SETTLE, SAMPLE, HOLD, FAIL);
  - default parameter constants;
  - a localparam helper for counter widths.
- Sub-module sync_2ff: generic 2-stage synchroniser with synchronous active-high reset, reused for other cells.

Test Plan:
- Trial timing, defaults, vn_en=0, cell model Q follows an LFSR:
  - en=1 sampled at edge 0 -> cell_r=cell_s=1 after edges 0-1, 0 after edges 2-5.
  - Raw bits captured at edges 7,14,...,56; data_valid=1 after edge 56.
  - data_out = the 8 model bits, MSB first.
- Back-pressure:
  - data_ready=0 for 20 cycles -> data_valid stays 1, data_out stable, cell_r=cell_s=0.
  - data_ready=1 -> handshake; data_valid=0 and EXCITE on next cycle.
- Von Neumann, raw sequence 0,1,1,0,0,0,1,1,1,0 with vn_en=1:
  - Emits 0,1,1; counter=3; no data_valid.
  - Continue to 8 emitted bits -> word matches the expected pairs.
- RCT, cell Q forced to 1:
  - Failure after the 16th sample (edge 112) -> health_fail=1, state FAIL, data_valid=0.
  - Persists with en toggling until rst=1 -> all outputs 0.
- Abort:
  - en=0 after 3 accepted bits -> IDLE next edge.
  - Re-enable -> word holds only new bits; counter restarted from 0.
- Reset mid-HOLD:
  - rst=1 for one cycle while data_valid=1 -> data_valid=0, data_out=0, IDLE.

Source files
------------

// File: rtl/trng_pkg.sv
// trng_pkg: shared state encoding, default parameters and width helper for TRNG cell control
package trng_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXCITE,
        SETTLE,
        SAMPLE,
        HOLD,
        FAIL
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_EXCITE_CYC = 2;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_RCT_LIMIT  = 16;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-stage synchroniser with synchronous active-high reset
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // two flops in series give the asynchronous input time to resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/trng_cell_ctrl.sv
// trng_cell_ctrl: RS-latch entropy cell sequencer with debiasing, repetition-count test and word packing
module trng_cell_ctrl
    import trng_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EXCITE_CYC = DEF_EXCITE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int RCT_LIMIT  = DEF_RCT_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             vn_en,
    input  logic             cell_q,
    output logic             cell_r,
    output logic             cell_s,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             health_fail
);

    localparam int CW = cnt_w((EXCITE_CYC > SETTLE_CYC) ? EXCITE_CYC : SETTLE_CYC);
    localparam int BW = cnt_w(WIDTH);
    localparam int RW = cnt_w(RCT_LIMIT);

    localparam logic [CW-1:0] EX_LAST = CW'(EXCITE_CYC - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(WIDTH - 1);
    localparam logic [RW-1:0] RLIM    = RW'(RCT_LIMIT);
    localparam logic [RW-1:0] RONE    = RW'(1);

    if (SETTLE_CYC < 2) begin : g_bad_settle
        $error("SETTLE_CYC must be >= 2 to cover synchroniser latency");
    end
    if (EXCITE_CYC < 1) begin : g_bad_excite
        $error("EXCITE_CYC must be >= 1");
    end
    if (RCT_LIMIT < 2) begin : g_bad_rct
        $error("RCT_LIMIT must be >= 2");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("WIDTH must be >= 2");
    end

    state_t          state, state_n;
    logic [CW-1:0]   cyc;
    logic [BW-1:0]   bcnt;
    logic [RW-1:0]   run, run_n;
    logic [WIDTH-1:0] sr;
    logic            q_sync;
    logic            last, have, first, vn, rs;
    logic            rct_hit, emit, ebit, word_done, discard;

    sync_2ff #(.W(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (cell_q),
        .q   (q_sync)
    );

    // raw-bit evaluation used at the closing edge of SAMPLE: run length, debias pairing, word completion
    always_comb begin
        run_n     = (run != '0 && q_sync == last) ? ((run == RLIM) ? run : run + 1'b1) : RONE;
        rct_hit   = run_n == RLIM;
        emit      = vn ? (have && first != q_sync) : 1'b1;
        ebit      = vn ? first : q_sync;
        word_done = emit && bcnt == BC_LAST;
    end

    // trial sequencing; any drop of en during a trial abandons it, FAIL is left only by reset
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = en ? EXCITE : IDLE;
            EXCITE:  state_n = !en ? IDLE : (cyc == EX_LAST) ? SETTLE : EXCITE;
            SETTLE:  state_n = !en ? IDLE : (cyc == ST_LAST) ? SAMPLE : SETTLE;
            SAMPLE:  state_n = !en ? IDLE : rct_hit ? FAIL : word_done ? HOLD : EXCITE;
            HOLD:    state_n = !data_ready ? HOLD : en ? EXCITE : IDLE;
            FAIL:    state_n = FAIL;
            default: state_n = IDLE;
        endcase
        discard = state_n == IDLE || state_n == FAIL;
    end

    // state, phase counter and the cell drive, which is registered from the next state so R and S share one flop
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cyc   <= '0;
            rs    <= 1'b0;
        end else begin
            state <= state_n;
            cyc   <= (state_n != state) ? '0 : cyc + 1'b1;
            rs    <= state_n == EXCITE;
        end
    end

    // debias mode is only allowed to change while idle
    always_ff @(posedge clk) begin
        if (rst)
            vn <= 1'b0;
        else if (state == IDLE)
            vn <= vn_en;
    end

    // health run, debias pair slot and packing; leaving for IDLE or FAIL throws the partial word away
    always_ff @(posedge clk) begin
        if (rst || discard) begin
            sr    <= '0;
            bcnt  <= '0;
            run   <= '0;
            last  <= 1'b0;
            have  <= 1'b0;
            first <= 1'b0;
        end else if (state == SAMPLE) begin
            last <= q_sync;
            run  <= run_n;
            if (vn) begin
                have  <= !have;
                first <= have ? first : q_sync;
            end
            if (emit) begin
                sr   <= {sr[WIDTH-2:0], ebit};
                bcnt <= word_done ? '0 : bcnt + 1'b1;
            end
        end
    end

    assign cell_r      = rs;
    assign cell_s      = rs;
    assign data_out    = sr;
    assign data_valid  = state == HOLD;
    assign health_fail = state == FAIL;

endmodule

// File: tb/tb_trng_cell_ctrl.sv
// tb_trng_cell_ctrl: randomized and directed checks of trng_cell_ctrl against a transaction-level model
module tb_trng_cell_ctrl;

    localparam int W  = 8;
    localparam int RL = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         vn_en = 1'b0;
    logic         cell_q = 1'b0;
    logic         data_ready = 1'b0;
    logic         cell_r, cell_s, data_valid, health_fail;
    logic [W-1:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;
    int hs = 0;
    int src_mode = 0;
    bit rand_ready = 0;
    bit dir_q[$];

    logic [W-1:0] m_sr;
    int           m_cnt, m_run;
    bit           m_have, m_first, m_last, m_vn, m_fail;
    logic [W-1:0] m_words[$];

    always #5 clk = ~clk;

    trng_cell_ctrl #(
        .WIDTH      (W),
        .EXCITE_CYC (2),
        .SETTLE_CYC (4),
        .RCT_LIMIT  (RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .vn_en       (vn_en),
        .cell_q      (cell_q),
        .cell_r      (cell_r),
        .cell_s      (cell_s),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .health_fail (health_fail)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_idle();
        m_sr   = '0;
        m_cnt  = 0;
        m_have = 0;
        m_run  = 0;
        m_vn   = vn_en;
    endfunction

    function automatic void model_reset();
        m_fail = 0;
        m_last = 0;
        m_words.delete();
        model_idle();
    endfunction

    function automatic void model_emit(input bit b);
        m_sr = {m_sr[W-2:0], b};
        m_cnt++;
        if (m_cnt == W) begin
            m_words.push_back(m_sr);
            m_cnt = 0;
        end
    endfunction

    function automatic void model_bit(input bit b);
        if (m_fail) return;
        m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
        m_last = b;
        if (m_run >= RL) begin
            m_fail = 1;
            m_sr   = '0;
            m_cnt  = 0;
            return;
        end
        if (!m_vn) begin
            model_emit(b);
        end else if (!m_have) begin
            m_have  = 1;
            m_first = b;
        end else begin
            m_have = 0;
            if (m_first != b) model_emit(m_first);
        end
    endfunction

    function automatic bit next_raw();
        bit b;
        if (src_mode == 2) return 1'b1;
        if (src_mode == 0 && dir_q.size() > 0) return dir_q.pop_front();
        b = 1'($urandom);
        if (m_run == RL - 1 && b == m_last) b = ~b;
        return b;
    endfunction

    // cell stand-in plus the every-cycle compare: one raw bit per trial, words checked at each handshake
    bit           r_prev = 0;
    bit           pv = 0;
    logic [W-1:0] pout = '0;
    bit           nb;
    always @(negedge clk) begin
        if (rst) begin
            r_prev = 0;
            pv     = 0;
        end else begin
            if (cell_r && !r_prev) begin
                nb     = next_raw();
                cell_q = nb;
                model_bit(nb);
            end
            r_prev = cell_r;
            check("rs_pair", cell_r, cell_s);
            if (data_valid) begin
                check("rs_in_hold", cell_r, 0);
                if (pv) check("out_stable", data_out, pout);
                if (data_ready) begin
                    if (m_words.size() == 0) check("word_expected", 0, 1);
                    else check("word", data_out, m_words.pop_front());
                    hs++;
                end
            end
            pv   = data_valid && !data_ready;
            pout = data_out;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            data_ready = ($urandom % 3) != 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        en         = 1'b0;
        data_ready = 1'b0;
        step(2);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!data_valid && k < budget) begin
            step(1);
            k++;
        end
        if (!data_valid) check(name, 0, 1);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #2000000;
        check("timeout", 0, 1);
        summary();
        $finish;
    end

    initial begin
        do_reset();
        check("rst_r", cell_r, 0);
        check("rst_s", cell_s, 0);
        check("rst_valid", data_valid, 0);
        check("rst_hf", health_fail, 0);
        check("rst_out", data_out, 0);

        // trial timing and first word
        src_mode = 0;
        vn_en    = 1'b0;
        dir_q    = '{1, 0, 1, 1, 0, 0, 1, 0};
        model_idle();
        en = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            step(1);
            check($sformatf("rs_edge%0d", k), cell_r, (k < 2 || k == 7) ? 1 : 0);
        end
        step(48);
        check("valid_e55", data_valid, 0);
        step(1);
        check("valid_e56", data_valid, 1);
        check("word_b2", data_out, 8'hB2);
        check("model_b2", m_words[0], 8'hB2);

        // back-pressure
        for (int k = 0; k < 20; k++) begin
            step(1);
            check("bp_valid", data_valid, 1);
            check("bp_out", data_out, 8'hB2);
            check("bp_r", cell_r, 0);
        end
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        check("hs_valid", data_valid, 0);
        check("hs_excite", cell_r, 1);

        // von Neumann debiasing
        do_reset();
        vn_en = 1'b1;
        dir_q = '{0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0};
        model_idle();
        en = 1'b1;
        step(71);
        check("vn_no_valid", data_valid, 0);
        check("vn_model_cnt", m_cnt, 3);
        check("vn_model_bits", m_sr[2:0], 3'b011);
        wait_valid("vn_valid", 200);
        check("vn_word", data_out, 8'h6B);
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;

        // repetition-count failure
        do_reset();
        vn_en    = 1'b1;
        src_mode = 2;
        model_idle();
        en = 1'b1;
        step(112);
        check("rct_e111", health_fail, 0);
        step(1);
        check("rct_e112", health_fail, 1);
        check("rct_model", health_fail, m_fail);
        check("rct_valid", data_valid, 0);
        for (int k = 0; k < 6; k++) begin
            en = ~en;
            step(3);
            check("fail_sticky", health_fail, 1);
            check("fail_valid", data_valid, 0);
            check("fail_r", cell_r, 0);
        end
        do_reset();
        src_mode = 0;
        check("fail_rst_hf", health_fail, 0);
        check("fail_rst_r", cell_r, 0);
        check("fail_rst_valid", data_valid, 0);
        check("fail_rst_out", data_out, 0);

        // abort after three accepted bits, then a fresh word
        vn_en = 1'b0;
        dir_q = '{1, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1};
        model_idle();
        en = 1'b1;
        step(22);
        check("abort_excite", cell_r, 1);
        en = 1'b0;
        step(1);
        check("abort_idle", cell_r, 0);
        step(3);
        check("abort_stays", cell_r, 0);
        model_idle();
        en = 1'b1;
        wait_valid("abort_valid", 200);
        check("abort_word", data_out, 8'h39);

        // reset while holding a word
        rst = 1'b1;
        en  = 1'b0;
        step(1);
        rst = 1'b0;
        model_reset();
        check("rst_hold_valid", data_valid, 0);
        check("rst_hold_out", data_out, 0);
        check("rst_hold_r", cell_r, 0);
        step(3);
        check("rst_hold_idle", cell_r, 0);

        // randomized segments with random back-pressure
        do_reset();
        src_mode   = 1;
        rand_ready = 1;
        for (int s = 0; s < 4; s++) begin
            int start;
            int k;
            vn_en = 1'($urandom);
            model_idle();
            start = hs;
            en    = 1'b1;
            k     = 0;
            while (!(hs == start + 2 && data_valid) && k < 4000) begin
                step(1);
                k++;
            end
            check("seg_third_word", (hs == start + 2 && data_valid) ? 1 : 0, 1);
            en = 1'b0;
            k  = 0;
            while (hs != start + 3 && k < 200) begin
                step(1);
                k++;
            end
            check("seg_handshakes", hs - start, 3);
            step(3);
        end
        rand_ready = 0;
        data_ready = 1'b0;
        step(2);
        check("rand_left_words", m_words.size(), 0);

        summary();
        $finish;
    end

endmodule
